// File: rtl/acq_trig_pkg.sv
// Shared types and widths for the acquisition trigger master.
// Latency: none (declarations only).
// Backpressure: none.
package acq_trig_pkg;

    // Handshake sequencer states
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARM    = 3'd1,
        TRIG   = 3'd2,
        WAIT   = 3'd3,
        REPORT = 3'd4
    } acq_state_e;

    localparam int TRIG_COUNT_W = 16;
    localparam int DROP_COUNT_W = 8;
    localparam int TS_W         = 32;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [DROP_COUNT_W-1:0] sat_inc(input logic [DROP_COUNT_W-1:0] v);
        return (v == '1) ? v : v + DROP_COUNT_W'(1);
    endfunction

endpackage

// File: rtl/acq_trig_master_if.sv
// Run-control side of the trigger master: request, per-run config, status and counters.
// Latency: wires only; timing is set by the module driving the slave modport.
// Backpressure: trig_req is a one-cycle pulse; requests arriving while busy are dropped and counted.
interface acq_trig_master_if #(
    parameter int NUM_CH    = 5,
    parameter int TIMEOUT_W = 20
);
    import acq_trig_pkg::*;

    logic                    trig_req;
    logic [NUM_CH-1:0]       enable_mask;
    logic [TIMEOUT_W-1:0]    timeout_lim;
    logic                    busy;
    logic                    done;
    logic                    timeout_err;
    logic [NUM_CH-1:0]       done_status;
    logic [TRIG_COUNT_W-1:0] trig_count;
    logic [DROP_COUNT_W-1:0] drop_count;

    // Run-control register block side
    modport master (
        output trig_req, enable_mask, timeout_lim,
        input  busy, done, timeout_err, done_status, trig_count, drop_count
    );

    // Trigger master side
    modport slave (
        input  trig_req, enable_mask, timeout_lim,
        output busy, done, timeout_err, done_status, trig_count, drop_count
    );

endinterface

// File: rtl/acq_trig_master_sync_2ff.sv
// Two-flop synchroniser bank for level signals from another clock domain.
// Latency: 2 clkin cycles.
// Backpressure: none; samples every cycle.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clkin,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Metastability filter: first stage may go metastable, second stage settles it
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/acq_trig_master.sv
// Master end of the channel trigger/done handshake: pulses acq_trig, collects acq_done, reports status/timeout.
// Latency: accept->ARM 1 cycle, trigger TRIG_WIDTH cycles, done reported >=4 cycles after last channel done edge.
// Backpressure: busy while a run is in flight; trig_req while busy is dropped and counted. Optional ACQ_TRIG_TIMESTAMP_EN adds trig_timestamp.
module acq_trig_master
    import acq_trig_pkg::*;
#(
    parameter int NUM_CH     = 5,
    parameter int TRIG_WIDTH = 4,
    parameter int TIMEOUT_W  = 20
) (
    input  logic              clkin,
    input  logic              rst_n,
    acq_trig_master_if.slave  ctl,
    output logic [NUM_CH-1:0] acq_trig,
    input  logic [NUM_CH-1:0] acq_done
`ifdef ACQ_TRIG_TIMESTAMP_EN
    ,
    output logic [TS_W-1:0]   trig_timestamp
`endif
);

    localparam int TW_W = (TRIG_WIDTH > 1) ? $clog2(TRIG_WIDTH) : 1;

    acq_state_e              state_q;
    logic [NUM_CH-1:0]       mask_q;
    logic [TIMEOUT_W-1:0]    lim_q;
    logic [TIMEOUT_W-1:0]    tmo_q;
    logic [TW_W-1:0]         tw_q;
    logic [NUM_CH-1:0]       acq_trig_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    terr_q;
    logic [NUM_CH-1:0]       status_q;
    logic [TRIG_COUNT_W-1:0] tc_q;
    logic [DROP_COUNT_W-1:0] dc_q;
    logic [NUM_CH-1:0]       done_prev_q;

    logic [NUM_CH-1:0]       done_s;
    logic [NUM_CH-1:0]       done_rise;
    logic                    tmo_hit;
    logic                    trig_last;
    logic                    accept;

    sync_2ff #(.WIDTH(NUM_CH)) u_done_sync (
        .clkin (clkin),
        .rst_n (rst_n),
        .d_i   (acq_done),
        .q_o   (done_s)
    );

    // Only fresh rising edges on enabled channels count; a level stuck high from the last run never does
    assign done_rise = done_s & ~done_prev_q & mask_q;
    // A zero limit disables the timeout entirely
    assign tmo_hit   = (lim_q != '0) && (tmo_q == lim_q);
    assign trig_last = (tw_q == TW_W'(TRIG_WIDTH - 1));
    assign accept    = ctl.trig_req && (ctl.enable_mask != '0);

    // History of the synchronised done levels for edge detection
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            done_prev_q <= '0;
        end else begin
            done_prev_q <= done_s;
        end
    end

`ifdef ACQ_TRIG_TIMESTAMP_EN
    logic [TS_W-1:0] ts_cnt_q;
    logic [TS_W-1:0] trig_ts_q;

    // Free-running time base, wraps silently
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            ts_cnt_q <= '0;
        end else begin
            ts_cnt_q <= ts_cnt_q + TS_W'(1);
        end
    end

    assign trig_timestamp = trig_ts_q;
`endif

    // Run sequencer: all outputs and counters are registered here
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            mask_q     <= '0;
            lim_q      <= '0;
            tmo_q      <= '0;
            tw_q       <= '0;
            acq_trig_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            terr_q     <= 1'b0;
            status_q   <= '0;
            tc_q       <= '0;
            dc_q       <= '0;
`ifdef ACQ_TRIG_TIMESTAMP_EN
            trig_ts_q  <= '0;
`endif
        end else begin
            done_q <= 1'b0;

            // Anything outside IDLE, including the REPORT cycle, cannot start a run
            if (ctl.trig_req && (state_q != IDLE)) begin
                dc_q <= sat_inc(dc_q);
            end

            // One timeout count spans ARM, TRIG and WAIT; it parks at the limit so a
            // limit reached during TRIG is still seen once WAIT starts
            if ((state_q inside {ARM, TRIG, WAIT}) && !tmo_hit) begin
                tmo_q <= tmo_q + TIMEOUT_W'(1);
            end

            // Done edges are captured while triggering as well as while waiting
            if (state_q inside {TRIG, WAIT}) begin
                status_q <= status_q | done_rise;
            end

            case (state_q)
                IDLE: begin
                    if (accept) begin
                        mask_q   <= ctl.enable_mask;
                        lim_q    <= ctl.timeout_lim;
                        status_q <= '0;
                        terr_q   <= 1'b0;
                        tmo_q    <= '0;
                        tc_q     <= tc_q + TRIG_COUNT_W'(1);
                        busy_q   <= 1'b1;
                        state_q  <= ARM;
                    end
                end
                ARM: begin
                    // Hold off until every enabled channel has dropped its previous done
                    if ((done_s & mask_q) == '0) begin
                        acq_trig_q <= mask_q;
                        tw_q       <= '0;
                        state_q    <= TRIG;
`ifdef ACQ_TRIG_TIMESTAMP_EN
                        trig_ts_q  <= ts_cnt_q + TS_W'(1);
`endif
                    end else if (tmo_hit) begin
                        terr_q  <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= REPORT;
                    end
                end
                TRIG: begin
                    if (trig_last) begin
                        acq_trig_q <= '0;
                        state_q    <= WAIT;
                    end else begin
                        tw_q <= tw_q + TW_W'(1);
                    end
                end
                WAIT: begin
                    // Full completion wins over a coincident timeout
                    if (status_q == mask_q) begin
                        done_q  <= 1'b1;
                        state_q <= REPORT;
                    end else if (tmo_hit) begin
                        terr_q  <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= REPORT;
                    end
                end
                REPORT: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    acq_trig_q <= '0;
                    busy_q     <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    assign acq_trig        = acq_trig_q;
    assign ctl.busy        = busy_q;
    assign ctl.done        = done_q;
    assign ctl.timeout_err = terr_q;
    assign ctl.done_status = status_q;
    assign ctl.trig_count  = tc_q;
    assign ctl.drop_count  = dc_q;

endmodule

// File: tb/tb_acq_trig_master.sv
// Bench for acq_trig_master: table of runs with a channel model and a done scoreboard, plus hand sequences.
// Latency: checks trigger width, done latency windows and exact timeout latency.
// Backpressure: drives trig_req while busy and checks the drop counter, including saturation.
module tb_acq_trig_master;
    import acq_trig_pkg::*;

    localparam int NUM_CH     = 5;
    localparam int TRIG_WIDTH = 4;
    localparam int TIMEOUT_W  = 20;
    localparam logic [11:0] NONE = 12'hFFF;

    typedef struct packed {
        logic [NUM_CH-1:0]       mask;
        logic [TIMEOUT_W-1:0]    lim;
        logic [NUM_CH-1:0][11:0] dly;
        logic [NUM_CH-1:0]       status;
        logic                    terr;
        logic                    chk_lat;
        int                      lat_lo;
        int                      lat_hi;
    } vec_t;

    typedef struct packed {
        logic [NUM_CH-1:0]       status;
        logic                    terr;
        logic [TRIG_COUNT_W-1:0] tc;
        logic                    chk_lat;
        int                      lat_lo;
        int                      lat_hi;
    } exp_t;

    logic              clkin = 1'b0;
    logic              rst_n = 1'b0;
    logic [NUM_CH-1:0] acq_trig;
    logic [NUM_CH-1:0] acq_done = '0;

    acq_trig_master_if #(.NUM_CH(NUM_CH), .TIMEOUT_W(TIMEOUT_W)) ctl ();

`ifdef ACQ_TRIG_TIMESTAMP_EN
    logic [TS_W-1:0] trig_timestamp;
`endif

    acq_trig_master #(
        .NUM_CH     (NUM_CH),
        .TRIG_WIDTH (TRIG_WIDTH),
        .TIMEOUT_W  (TIMEOUT_W)
    ) dut (
        .clkin          (clkin),
        .rst_n          (rst_n),
        .ctl            (ctl),
        .acq_trig       (acq_trig),
        .acq_done       (acq_done)
`ifdef ACQ_TRIG_TIMESTAMP_EN
        ,
        .trig_timestamp (trig_timestamp)
`endif
    );

    always #5 clkin = ~clkin;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t sb[$];
    exp_t mon_e;
    int   trig_entries = 0;
    int   t0 = 0;
    int   tw = 0;
    int   done_cnt = 0;
    int   tc_exp = 0;
    int   drop_exp = 0;
    logic [NUM_CH-1:0] exp_mask = '0;
    vec_t tbl [6];

    always @(posedge clkin) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic check_rng(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic tick();
        @(negedge clkin);
        #1;
    endtask

    function automatic logic [NUM_CH-1:0][11:0] mk_dly(input int c0, input int c1, input int c2,
                                                       input int c3, input int c4);
        logic [NUM_CH-1:0][11:0] r;
        r[0] = (c0 < 0) ? NONE : 12'(c0);
        r[1] = (c1 < 0) ? NONE : 12'(c1);
        r[2] = (c2 < 0) ? NONE : 12'(c2);
        r[3] = (c3 < 0) ? NONE : 12'(c3);
        r[4] = (c4 < 0) ? NONE : 12'(c4);
        return r;
    endfunction

    function automatic vec_t mk_vec(input logic [NUM_CH-1:0] mask, input int lim,
                                    input logic [NUM_CH-1:0][11:0] dly, input logic [NUM_CH-1:0] status,
                                    input logic terr, input logic chk_lat, input int lo, input int hi);
        vec_t v;
        v.mask = mask; v.lim = TIMEOUT_W'(lim); v.dly = dly; v.status = status;
        v.terr = terr; v.chk_lat = chk_lat; v.lat_lo = lo; v.lat_hi = hi;
        return v;
    endfunction

`ifdef ACQ_TRIG_TIMESTAMP_EN
    logic [TS_W-1:0] ts_cyc;
    logic [TS_W-1:0] ts_prev = '0;
    int              ts_prev_cyc = 0;
    bit              ts_prev_vld = 1'b0;

    always @(posedge clkin or negedge rst_n) begin
        if (!rst_n) ts_cyc <= '0;
        else        ts_cyc <= ts_cyc + 32'd1;
    end
`endif

    // Output monitor: trigger pulse shape and done scoreboard
    always @(negedge clkin) begin
        if (!rst_n) begin
            tw = 0;
`ifdef ACQ_TRIG_TIMESTAMP_EN
            ts_prev_vld = 1'b0;
`endif
        end else begin
            if (acq_trig != '0) begin
                if (tw == 0) begin
                    trig_entries++;
                    t0 = cyc;
`ifdef ACQ_TRIG_TIMESTAMP_EN
                    check("ts_abs", trig_timestamp, ts_cyc);
                    if (ts_prev_vld)
                        check("ts_delta", trig_timestamp - ts_prev, 32'(cyc - ts_prev_cyc));
                    ts_prev = trig_timestamp;
                    ts_prev_cyc = cyc;
                    ts_prev_vld = 1'b1;
`endif
                end
                tw++;
                check("acq_trig_bits", 32'(acq_trig), 32'(exp_mask));
            end else if (tw != 0) begin
                check("acq_trig_width", 32'(tw), 32'(TRIG_WIDTH));
                tw = 0;
            end
            if (ctl.done) begin
                done_cnt++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done actual=1 required=0");
                end else begin
                    mon_e = sb.pop_front();
                    check("done_status", 32'(ctl.done_status), 32'(mon_e.status));
                    check("timeout_err", 32'(ctl.timeout_err), 32'(mon_e.terr));
                    check("trig_count", 32'(ctl.trig_count), 32'(mon_e.tc));
                    check("busy_at_done", 32'(ctl.busy), 32'd1);
                    if (mon_e.chk_lat) check_rng("done_latency", cyc - t0, mon_e.lat_lo, mon_e.lat_hi);
                end
            end
        end
    end

    // One acquisition: accept, channel model, optional busy requests, completion checks
    task automatic run(input vec_t v, input int spam, input logic [NUM_CH-1:0] hold, input int release_after);
        exp_t e;
        int   n0;
        int   e0;
        int   pulses;
        bit   got;
        if (hold != '0) begin
            acq_done = hold;
            repeat (4) tick();
        end
        tc_exp++;
        e.status = v.status; e.terr = v.terr; e.tc = TRIG_COUNT_W'(tc_exp);
        e.chk_lat = v.chk_lat; e.lat_lo = v.lat_lo; e.lat_hi = v.lat_hi;
        sb.push_back(e);
        exp_mask = v.mask;
        n0 = done_cnt;
        e0 = trig_entries;
        ctl.enable_mask = v.mask;
        ctl.timeout_lim = v.lim;
        ctl.trig_req = 1'b1;
        tick();
        ctl.trig_req = 1'b0;
        ctl.enable_mask = ~v.mask;
        ctl.timeout_lim = TIMEOUT_W'(3);
        check("busy_rise", 32'(ctl.busy), 32'd1);
        pulses = 0;
        got = 1'b0;
        for (int k = 0; k < 4000 && !got; k++) begin
            ctl.trig_req = 1'b0;
            if (release_after >= 0 && k == release_after) acq_done = acq_done & ~hold;
            if (trig_entries != e0) begin
                for (int ch = 0; ch < NUM_CH; ch++)
                    if (v.dly[ch] != NONE && (cyc - t0) == int'(v.dly[ch])) acq_done[ch] = 1'b1;
                if (pulses < spam && ctl.busy && acq_trig == '0 && (k % 2) == 0) begin
                    ctl.trig_req = 1'b1;
                    pulses++;
                end
            end
            tick();
            if (done_cnt != n0) got = 1'b1;
        end
        ctl.trig_req = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL run_budget actual=no_done required=done");
            sb.delete();
        end
        drop_exp = (drop_exp + pulses > 255) ? 255 : drop_exp + pulses;
        tick();
        check("done_single", 32'(ctl.done), 32'd0);
        check("busy_fall", 32'(ctl.busy), 32'd0);
        check("status_held", 32'(ctl.done_status), 32'(v.status));
        check("drop_count", 32'(ctl.drop_count), 32'(drop_exp));
        acq_done = '0;
        repeat (4) tick();
    endtask

    initial begin
        int e0;
        int n0;
        ctl.trig_req = 1'b0;
        ctl.enable_mask = '0;
        ctl.timeout_lim = '0;
        tick();
        tick();
        check("rst_acq_trig", 32'(acq_trig), 32'd0);
        check("rst_busy", 32'(ctl.busy), 32'd0);
        check("rst_done", 32'(ctl.done), 32'd0);
        check("rst_terr", 32'(ctl.timeout_err), 32'd0);
        check("rst_status", 32'(ctl.done_status), 32'd0);
        check("rst_trig_count", 32'(ctl.trig_count), 32'd0);
        check("rst_drop_count", 32'(ctl.drop_count), 32'd0);
        rst_n = 1'b1;
        tick();

        // Unmasked ch1 answering in run 0 must be ignored; run 5 answers after its timeout
        tbl[0] = mk_vec(5'b10101, 1000, mk_dly(50, 30, 60, -1, 70), 5'b10101, 1'b0, 1'b1, 73, 75);
        tbl[1] = mk_vec(5'b00011,  200, mk_dly(40, -1, -1, -1, -1), 5'b00001, 1'b1, 1'b1, 200, 200);
        tbl[2] = mk_vec(5'b11111,    0, mk_dly(5, 10, 15, 20, 25), 5'b11111, 1'b0, 1'b1, 28, 30);
        tbl[3] = mk_vec(5'b01000,    1, mk_dly(-1, -1, -1, -1, -1), 5'b00000, 1'b1, 1'b0, 0, 0);
        tbl[4] = mk_vec(5'b10000,  300, mk_dly(-1, -1, -1, -1, 0), 5'b10000, 1'b0, 1'b1, 3, 5);
        tbl[5] = mk_vec(5'b00100,   60, mk_dly(-1, -1, 80, -1, -1), 5'b00000, 1'b1, 1'b1, 60, 60);
        for (int i = 0; i < 6; i++) run(tbl[i], 0, '0, -1);

        // Empty mask is not a request
        e0 = trig_entries;
        ctl.enable_mask = '0;
        ctl.trig_req = 1'b1;
        tick();
        ctl.trig_req = 1'b0;
        repeat (3) tick();
        check("zero_mask_busy", 32'(ctl.busy), 32'd0);
        check("zero_mask_trig_count", 32'(ctl.trig_count), 32'(tc_exp));
        check("zero_mask_drop", 32'(ctl.drop_count), 32'(drop_exp));
        check("zero_mask_no_trig", 32'(trig_entries - e0), 32'd0);

        // Stale done held high: stuck in ARM until timeout, never triggers
        e0 = trig_entries;
        run(mk_vec(5'b00010, 100, mk_dly(-1, -1, -1, -1, -1), 5'b00000, 1'b1, 1'b0, 0, 0), 0, 5'b00010, -1);
        check("stale_no_trig", 32'(trig_entries - e0), 32'd0);
        // Stale done released early: trigger proceeds and the new edge counts
        run(mk_vec(5'b00010, 100, mk_dly(-1, 10, -1, -1, -1), 5'b00010, 1'b0, 1'b1, 13, 15), 0, 5'b00010, 20);
        check("stale_release_trig", 32'(trig_entries - e0), 32'd1);

        // Requests while busy: three, then enough to saturate
        run(mk_vec(5'b00001, 150, mk_dly(-1, -1, -1, -1, -1), 5'b00000, 1'b1, 1'b1, 150, 150), 3, '0, -1);
        check("drop_three", 32'(ctl.drop_count), 32'd3);
        run(mk_vec(5'b00001, 700, mk_dly(-1, -1, -1, -1, -1), 5'b00000, 1'b1, 1'b1, 700, 700), 300, '0, -1);
        check("drop_saturated", 32'(ctl.drop_count), 32'd255);

        // Reset on the second trigger cycle
        e0 = trig_entries;
        exp_mask = 5'b00111;
        ctl.enable_mask = 5'b00111;
        ctl.timeout_lim = TIMEOUT_W'(500);
        ctl.trig_req = 1'b1;
        tick();
        ctl.trig_req = 1'b0;
        for (int k = 0; k < 20 && trig_entries == e0; k++) tick();
        check("rst_mid_trig_started", 32'(trig_entries - e0), 32'd1);
        tick();
        rst_n = 1'b0;
        #1;
        check("rst_mid_acq_trig", 32'(acq_trig), 32'd0);
        check("rst_mid_busy", 32'(ctl.busy), 32'd0);
        check("rst_mid_trig_count", 32'(ctl.trig_count), 32'd0);
        check("rst_mid_drop_count", 32'(ctl.drop_count), 32'd0);
        check("rst_mid_status", 32'(ctl.done_status), 32'd0);
        tc_exp = 0;
        drop_exp = 0;
        n0 = done_cnt;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("rst_mid_no_done", 32'(done_cnt - n0), 32'd0);

        // Recovery after reset
        run(tbl[0], 0, '0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
